wb_gpio: RTL
============

# wb_gpio

Wishbone slave giving the LM32 firmware access to board switches, push-buttons and LEDs, with per-bit edge interrupts. It sits on the conbus as a peer of the UART and timer slaves, in the 15-bit decoded window 0x7002. Input pins are synchronised, optionally debounced and edge-detected. Output pins are driven from a software-written register. The interrupt output feeds one bit of the CPU's `intr_n` vector, inverted.

## Interface
- `clk_freq`, 50000000 — clock frequency in Hz; used for the debounce prescaler.
- `in_width`, 14 — number of input pins, 1..32 (default layout: `{key_n[3:0], sw[9:0]}`).
- `out_width`, 18 — number of output pins, 1..32 (default layout: `{ledg[7:0], ledr[9:0]}`).
- `debounce_ms`, 10 — debounce sample period in ms; ignored without the macro.

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — reset, asynchronous and active-high.
- `wb_adr_i` in 32 — byte address; only `[4:2]` is decoded.
- `wb_dat_i` in 32 — write data.
- `wb_dat_o` out 32 — read data.
- `wb_sel_i` in 4 — byte lane enables.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i` in 1 — Wishbone classic strobe, cycle and write.
- `wb_ack_o` out 1 — acknowledge.
- `intr` out 1 — active-high level interrupt.
- `gpio_i` in `in_width` — asynchronous input pins.
- `gpio_o` out `out_width` — output pins.

## Operation
Register map (word offsets; unused high bits read 0; a write to a read-only register is ignored):
- 0x00 IN — filtered input value. Read-only.
- 0x04 OUT — drives `gpio_o`. Read/write.
- 0x08 MASK — interrupt enable per input bit. Read/write.
- 0x0C EDGE — per input bit: 1 selects rising edge, 0 selects falling edge. Read/write.
- 0x10 PEND — pending edge flags. Writing 1 clears a bit; writing 0 leaves it unchanged.
- 0x14..0x1C — read 0, writes ignored, access still acknowledged.

Bus behaviour:
- All writes honour `wb_sel_i` per byte, including the write-1-to-clear on PEND.

Input path:
- `gpio_i` → 2-flop synchroniser → `sync`.
- Without debounce, `filt = sync`.
- `filt_d` is `filt` delayed by one cycle.
- Edge event per bit is computed as `EDGE ? (filt & ~filt_d) : (~filt & filt_d)`.
- PEND next value: `(PEND & ~clear) | event`. If set and clear hit the same bit in the same cycle, set wins.
- Events set PEND regardless of MASK.
- `intr` is registered: `intr <= |(PEND & MASK)`.
- After reset, inputs idling high (e.g. `key_n`) produce rising edges as `filt` leaves 0 and can set PEND. Firmware clears PEND before enabling MASK.

## Timing
Reset values:
- `wb_ack_o` = 0, `wb_dat_o` = 0, `intr` = 0, `gpio_o` = 0.
- OUT, MASK, EDGE and PEND = 0; synchroniser, `filt`, `filt_d` and prescaler = 0.

Bus handshake:
- `wb_ack_o` asserts on the cycle after `wb_stb_i & wb_cyc_i & ~wb_ack_o`, is high for exactly one cycle, then returns low. Back-to-back accesses therefore complete every 2 cycles.
- `wb_dat_o` is registered and valid while `wb_ack_o` is high; it is 0 otherwise.
- A write takes effect at the same edge that raises `wb_ack_o`.
- The new OUT value appears on `gpio_o` at that edge (zero added latency).

Input latency without debounce (edge 1 samples the new pin level):
- `sync` updates at edge 2; it is visible in an IN read whose ack edge is edge 3 or later.
- PEND sets at edge 3.
- `intr` rises at edge 4.

Interrupt clear:
- A PEND clear at edge k drops `intr` at edge k+1.

Reset mid-transaction:
- Asynchronous reset clears everything immediately.
- An in-flight access is not acknowledged; the master must reissue it.

## Configuration
- `WB_GPIO_DEBOUNCE_EN` defined:
  - A prescaler produces a one-cycle `tick` every `clk_freq/1000*debounce_ms` cycles.
  - On each tick, `sample <= sync`.
  - If `sync == sample` on that tick, then `filt <= sync`.
  - A level change therefore reaches `filt` 1–2 periods after synchronisation; glitches shorter than one period are rejected.
- Undefined: no prescaler, and `filt = sync` as described under Operation.

## Structure
- Package `wb_gpio_pkg`:
  - Register offset constants `GPIO_IN`, `GPIO_OUT`, `GPIO_MASK`, `GPIO_EDGE`, `GPIO_PEND`.
  - Address decode width constant (3).
- Sub-module `gpio_debounce`:
  - Contains the prescaler and the sample/compare logic; parameterised by width and period.
  - Instantiated only under `WB_GPIO_DEBOUNCE_EN`.

## Test plan
- Reset, then read 0x00–0x1C: every register reads 0 except IN, which reads `gpio_i` after 2 cycles; each access acks exactly 1 cycle after `stb`.
- Write 0x04 = 0x0003_FFFF with sel = 4'b0001: OUT = 0x0000_00FF and `gpio_o` = 18'h000FF on the ack edge; an immediate read-back returns 0x0000_00FF.
- EDGE = 1, MASK = 1, `gpio_i[0]` 0→1: PEND[0] sets at edge 3 and `intr` = 1 at edge 4. Write 1 to PEND bit 0: `intr` = 0 one cycle after the ack.
- EDGE = 0, `gpio_i[0]` 1→0 at the same edge as a PEND clear write: PEND[0] stays 1 (set wins).
- With the macro defined, `debounce_ms` = 1 and `clk_freq` = 1 MHz: a 300-cycle pulse on `gpio_i[3]` never reaches IN; a 2500-cycle level change appears in IN within 2000 cycles + 2.
- Assert `reset` while `stb` is high and before ack: no ack, `gpio_o` = 0, `intr` = 0; after release, the access reissued by the master completes.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: register offsets, decode width and byte-lane helpers for the wb_gpio slave.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package wb_gpio_pkg;

    // Word-address bits decoded from the byte address (wb_adr_i[4:2]).
    localparam int ADR_W = 3;

    typedef logic [ADR_W-1:0] reg_adr_t;

    localparam reg_adr_t GPIO_IN   = 3'd0;
    localparam reg_adr_t GPIO_OUT  = 3'd1;
    localparam reg_adr_t GPIO_MASK = 3'd2;
    localparam reg_adr_t GPIO_EDGE = 3'd3;
    localparam reg_adr_t GPIO_PEND = 3'd4;

    // Expand the four byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Replace only the enabled byte lanes of a register with the bus write data.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = sel_mask(sel);
        return (old_val & ~m) | (new_val & m);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: prescaled sample-and-compare filter; a level must be seen on two consecutive ticks.
// Latency: a level change reaches filt 1-2 periods after it reaches sync.
// Backpressure: none; free-running, one tick every PERIOD cycles.
module gpio_debounce #(
    parameter int WIDTH  = 14,
    parameter int PERIOD = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] filt
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [WIDTH-1:0] sample;

    assign tick = (cnt == CNT_W'(PERIOD - 1));

    // Prescaler: wraps every PERIOD cycles, tick marks the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // On each tick remember the level and accept it once it has held for a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample <= '0;
            filt   <= '0;
        end else if (tick) begin
            sample <= sync;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == sample[i]) begin
                    filt[i] <= sync[i];
                end
            end
        end
    end

endmodule

// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone classic GPIO slave with synchronised inputs, edge-pending flags and a level interrupt.
// Latency: ack 1 cycle after strobe; pin change to intr 4 cycles (plus debounce when WB_GPIO_DEBOUNCE_EN).
// Backpressure: none; every strobe is acked after one cycle, back-to-back accesses every 2 cycles.
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int clk_freq    = 50000000,
    parameter int in_width    = 14,
    parameter int out_width   = 18,
    parameter int debounce_ms = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    output logic                 wb_ack_o,
    output logic                 intr,
    input  logic [in_width-1:0]  gpio_i,
    output logic [out_width-1:0] gpio_o
);

    logic [in_width-1:0]  sync_meta;
    logic [in_width-1:0]  sync;
    logic [in_width-1:0]  filt;
    logic [in_width-1:0]  filt_d;
    logic [in_width-1:0]  evt;
    logic [in_width-1:0]  clear;
    logic [in_width-1:0]  mask_q;
    logic [in_width-1:0]  edge_q;
    logic [in_width-1:0]  pend_q;
    logic [out_width-1:0] out_q;
    logic [31:0]          rd_dat;
    logic                 access;
    logic                 wr;
    reg_adr_t             adr;
    logic                 unused_bits;

    // A new access starts only while ack is low, which yields the one-cycle ack pulse.
    assign access = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr     = access & wb_we_i;
    assign adr    = wb_adr_i[ADR_W+1:2];
    assign gpio_o = out_q;

    assign unused_bits = ^{wb_adr_i[31:ADR_W+2], wb_adr_i[1:0], 32'(clk_freq), 32'(debounce_ms)};

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= gpio_i;
            sync      <= sync_meta;
        end
    end

`ifdef WB_GPIO_DEBOUNCE_EN
    gpio_debounce #(
        .WIDTH  (in_width),
        .PERIOD (clk_freq / 1000 * debounce_ms)
    ) u_debounce (
        .clk  (clk),
        .rst  (reset),
        .sync (sync),
        .filt (filt)
    );
`else
    assign filt = sync;
`endif

    // Per-bit edge selection and write-1-to-clear mask for PEND.
    assign evt   = (edge_q & filt & ~filt_d) | (~edge_q & ~filt & filt_d);
    assign clear = (wr && adr == GPIO_PEND) ? in_width'(wb_dat_i & sel_mask(wb_sel_i)) : '0;

    // Read mux; unused high bits and unmapped offsets read as zero.
    always_comb begin
        rd_dat = '0;
        case (adr)
            GPIO_IN:   rd_dat = 32'(filt);
            GPIO_OUT:  rd_dat = 32'(out_q);
            GPIO_MASK: rd_dat = 32'(mask_q);
            GPIO_EDGE: rd_dat = 32'(edge_q);
            GPIO_PEND: rd_dat = 32'(pend_q);
            default:   rd_dat = '0;
        endcase
    end

    // Bus side: registered ack/read data and byte-lane writes to the R/W registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            out_q    <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= (access && !wb_we_i) ? rd_dat : '0;
            if (wr && adr == GPIO_OUT) begin
                out_q <= out_width'(byte_merge(32'(out_q), wb_dat_i, wb_sel_i));
            end
            if (wr && adr == GPIO_MASK) begin
                mask_q <= in_width'(byte_merge(32'(mask_q), wb_dat_i, wb_sel_i));
            end
            if (wr && adr == GPIO_EDGE) begin
                edge_q <= in_width'(byte_merge(32'(edge_q), wb_dat_i, wb_sel_i));
            end
        end
    end

    // Edge history, pending flags (set beats clear) and the registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_d <= '0;
            pend_q <= '0;
            intr   <= 1'b0;
        end else begin
            filt_d <= filt;
            pend_q <= (pend_q & ~clear) | evt;
            intr   <= |(pend_q & mask_q);
        end
    end

endmodule
